// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard-control bundle between the pipeline datapath and the stall/flush sequencer
//
// master : datapath side, drives hazard information, receives register controls
// slave  : sequencer side (pipeline_hazard_ctrl)
// Signals:
//   halt_req, idex_memread, idex_rd, ifid_rs, ifid_rt,
//   exmem_memaccess, exmem_branch_taken                 datapath -> sequencer
//   pc_en, ifid_en, idex_en, exmem_en,
//   ifid_flush, idex_flush, exmem_flush,
//   memwb_bubble, halted, stall_cycles                  sequencer -> datapath
interface pipeline_hazard_ctrl_if #(
    parameter int SIZE_ADDR = 5,
    parameter int CNT_W     = 16
);
    logic                 halt_req;
    logic                 idex_memread;
    logic [SIZE_ADDR-1:0] idex_rd;
    logic [SIZE_ADDR-1:0] ifid_rs;
    logic [SIZE_ADDR-1:0] ifid_rt;
    logic                 exmem_memaccess;
    logic                 exmem_branch_taken;

    logic                 pc_en;
    logic                 ifid_en;
    logic                 idex_en;
    logic                 exmem_en;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 exmem_flush;
    logic                 memwb_bubble;
    logic                 halted;
    logic [CNT_W-1:0]     stall_cycles;

    modport master (
        output halt_req, idex_memread, idex_rd, ifid_rs, ifid_rt,
               exmem_memaccess, exmem_branch_taken,
        input  pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush,
               memwb_bubble, halted, stall_cycles
    );

    modport slave (
        input  halt_req, idex_memread, idex_rd, ifid_rs, ifid_rt,
               exmem_memaccess, exmem_branch_taken,
        output pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush,
               memwb_bubble, halted, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous reset, active-high
//   bus  : pipeline_hazard_ctrl_if.slave (hazard inputs, register enables/flushes,
//          memwb_bubble, halted, stall_cycles)
// States RUN / MEM_WAIT / DRAIN / HALTED; outputs are combinational from state and inputs.
module pipeline_hazard_ctrl #(
    parameter int SIZE_ADDR = 5,
    parameter int MEM_LAT   = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED} state_t;

    state_t               state, state_n;
    state_t               ret_state, ret_n;
    logic [WAIT_W-1:0]    wait_cnt, wait_n;
    logic [1:0]           drain_cnt, drain_n;
    logic [CNT_W-1:0]     stall_q;

    logic [SIZE_ADDR-1:0] rd, rs, rt;
    logic                 load_use;
    logic                 mem_freeze;

    logic pc_en, ifid_en, idex_en, exmem_en;
    logic ifid_flush, idex_flush, exmem_flush;
    logic memwb_bubble, halted;

    assign rd = bus.idex_rd;
    assign rs = bus.ifid_rs;
    assign rt = bus.ifid_rt;

    assign load_use   = bus.idex_memread && (rd != '0) && ((rd == rs) || (rd == rt));
    // With single-cycle memory there is nothing to wait for.
    assign mem_freeze = bus.exmem_memaccess && (MEM_LAT != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            ret_state <= S_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            stall_q   <= '0;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            wait_cnt  <= wait_n;
            drain_cnt <= drain_n;
            if (!pc_en && (state != S_HALTED) && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        state_n      = state;
        ret_n        = ret_state;
        wait_n       = wait_cnt;
        drain_n      = drain_cnt;

        case (state)
            S_RUN: begin
                if (mem_freeze) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_bubble = 1'b1;
                    state_n      = S_MEM_WAIT;
                    wait_n       = WAIT_INIT;
                    ret_n        = S_RUN;
                end else if (bus.exmem_branch_taken) begin
                    {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (bus.halt_req) begin
                    // PC keeps the address of the fetch being discarded so resume re-fetches it.
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    state_n    = S_DRAIN;
                    drain_n    = 2'd3;
                end
            end
            S_MEM_WAIT: begin
                if (wait_cnt != '0) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    memwb_bubble = 1'b1;
                    wait_n       = wait_cnt - WAIT_W'(1);
                end else begin
                    state_n = ret_state;
                end
                // A wait entered from a drain must not let the front end advance.
                if (ret_state == S_DRAIN) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            S_DRAIN: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                if (mem_freeze) begin
                    {ifid_en, idex_en, exmem_en} = 3'b000;
                    memwb_bubble = 1'b1;
                    state_n      = S_MEM_WAIT;
                    wait_n       = WAIT_INIT;
                    ret_n        = S_DRAIN;
                end else begin
                    if (bus.exmem_branch_taken) begin
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end
                    if (drain_cnt == 2'd0)
                        state_n = S_HALTED;
                    else
                        drain_n = drain_cnt - 2'd1;
                end
            end
            S_HALTED: begin
                {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                halted = 1'b1;
                if (!bus.halt_req)
                    state_n = S_RUN;
            end
            default: state_n = S_RUN;
        endcase

        // During reset every stage loads a bubble so no stale instruction survives.
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en}   = 4'b1111;
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            memwb_bubble = 1'b1;
            halted       = 1'b0;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.idex_en      = idex_en;
    assign bus.exmem_en     = exmem_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.halted       = halted;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if #(.SIZE_ADDR(5), .CNT_W(4))  bus();
    pipeline_hazard_ctrl_if #(.SIZE_ADDR(5), .CNT_W(16)) bus0();

    pipeline_hazard_ctrl #(.SIZE_ADDR(5), .MEM_LAT(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    pipeline_hazard_ctrl #(.SIZE_ADDR(5), .MEM_LAT(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    assign bus0.halt_req           = bus.halt_req;
    assign bus0.idex_memread       = bus.idex_memread;
    assign bus0.idex_rd            = bus.idex_rd;
    assign bus0.ifid_rs            = bus.ifid_rs;
    assign bus0.ifid_rt            = bus.ifid_rt;
    assign bus0.exmem_memaccess    = bus.exmem_memaccess;
    assign bus0.exmem_branch_taken = bus.exmem_branch_taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       r;
        logic       h;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ma;
        logic       br;
    } in_t;

    // {pc,ifid,idex,exmem en}, {ifid,idex,exmem flush}, bubble, halted, stall[3:0]
    typedef logic [12:0] out_t;

    int   errors = 0;
    int   checks = 0;
    out_t sb[$];

    function automatic in_t mi(logic r, logic h, logic mr, logic [4:0] rd,
                               logic [4:0] rs, logic [4:0] rt, logic ma, logic br);
        mi = '{r: r, h: h, mr: mr, rd: rd, rs: rs, rt: rt, ma: ma, br: br};
    endfunction

    function automatic out_t mo(logic [3:0] en, logic [2:0] fl, logic bub, logic hlt, int st);
        mo = {en, fl, bub, hlt, 4'(st)};
    endfunction

    function automatic out_t o_forced(int st); o_forced = mo(4'b1111, 3'b111, 1'b1, 1'b0, st); endfunction
    function automatic out_t o_def(int st);    o_def    = mo(4'b1111, 3'b000, 1'b0, 1'b0, st); endfunction
    function automatic out_t o_lu(int st);     o_lu     = mo(4'b0011, 3'b010, 1'b0, 1'b0, st); endfunction
    function automatic out_t o_frz(int st);    o_frz    = mo(4'b0000, 3'b000, 1'b1, 1'b0, st); endfunction
    function automatic out_t o_drn(int st);    o_drn    = mo(4'b0111, 3'b100, 1'b0, 1'b0, st); endfunction
    function automatic out_t o_hlt(int st);    o_hlt    = mo(4'b0000, 3'b000, 1'b0, 1'b1, st); endfunction

    function automatic out_t sample();
        sample = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                  bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
                  bus.memwb_bubble, bus.halted, bus.stall_cycles};
    endfunction

    function automatic out_t sample0();
        sample0 = {bus0.pc_en, bus0.ifid_en, bus0.idex_en, bus0.exmem_en,
                   bus0.ifid_flush, bus0.idex_flush, bus0.exmem_flush,
                   bus0.memwb_bubble, bus0.halted, bus0.stall_cycles[3:0]};
    endfunction

    task automatic drive(input in_t v);
        rst                    = v.r;
        bus.halt_req           = v.h;
        bus.idex_memread       = v.mr;
        bus.idex_rd            = v.rd;
        bus.ifid_rs            = v.rs;
        bus.ifid_rt            = v.rt;
        bus.exmem_memaccess    = v.ma;
        bus.exmem_branch_taken = v.br;
    endtask

    task automatic test_reset();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        iv = '{mi(1,1,1,8,8,0,1,1), mi(0,0,0,0,0,0,0,0)};
        ev = '{o_forced(0), o_def(0)};
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL reset[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        iv = '{mi(0,0,1,8,8,0,0,0), mi(0,0,1,8,3,8,0,0), mi(0,0,1,0,0,0,0,0),
               mi(0,0,0,8,8,0,0,0), mi(0,0,1,8,9,10,0,0), mi(0,0,0,0,0,0,0,0)};
        ev = '{o_lu(0), o_lu(1), o_def(2), o_def(2), o_def(2), o_def(2)};
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        iv = '{mi(1,0,0,0,0,0,0,0), mi(0,1,1,8,8,0,0,1), mi(0,0,1,8,8,0,0,0), mi(0,0,0,0,0,0,0,0)};
        ev = '{o_forced(2), mo(4'b1111, 3'b111, 1'b0, 1'b0, 0), o_lu(0), o_def(1)};
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL branch[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        iv = '{mi(1,0,0,0,0,0,0,0), mi(0,0,0,0,0,0,1,0), mi(0,1,1,8,8,0,1,1),
               mi(0,0,1,8,8,0,1,1), mi(0,0,0,0,0,0,1,0), mi(0,0,0,0,0,0,0,0),
               mi(0,0,0,0,0,0,0,0), mi(0,0,0,0,0,0,0,0)};
        ev = '{o_forced(1), o_frz(0), o_frz(1), o_def(2), o_frz(2), o_frz(3), o_def(4), o_def(4)};
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        iv = '{mi(1,0,0,0,0,0,0,0), mi(0,1,0,0,0,0,0,0), mi(0,1,0,0,0,0,0,0),
               mi(0,1,1,8,8,0,0,0), mi(0,0,0,0,0,0,0,0), mi(0,0,0,0,0,0,0,1),
               mi(0,1,0,0,0,0,0,0), mi(0,1,0,0,0,0,0,0), mi(0,0,0,0,0,0,0,0),
               mi(0,0,0,0,0,0,0,0), mi(0,0,0,0,0,0,0,0)};
        ev = '{o_forced(4), o_drn(0), o_drn(1), o_drn(2), o_drn(3),
               mo(4'b0111, 3'b111, 1'b0, 1'b0, 4), o_hlt(5), o_hlt(5), o_hlt(5),
               o_def(5), o_def(5)};
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL halt[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain_mem();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        iv = '{mi(1,0,0,0,0,0,0,0), mi(0,1,0,0,0,0,0,0), mi(0,1,0,0,0,0,0,0),
               mi(0,1,0,0,0,0,1,0), mi(0,1,0,0,0,0,1,0), mi(0,1,0,0,0,0,1,0),
               mi(0,1,0,0,0,0,0,0), mi(0,1,0,0,0,0,0,0), mi(0,1,0,0,0,0,0,0),
               mi(0,1,0,0,0,0,0,0), mi(0,0,0,0,0,0,0,0), mi(0,0,0,0,0,0,1,0),
               mi(1,0,0,0,0,0,1,0), mi(0,0,0,0,0,0,0,0), mi(0,0,0,0,0,0,0,0)};
        ev = '{o_forced(5), o_drn(0), o_drn(1),
               mo(4'b0000, 3'b100, 1'b1, 1'b0, 2), mo(4'b0000, 3'b100, 1'b1, 1'b0, 3),
               o_drn(4), o_drn(5), o_drn(6), o_drn(7), o_hlt(8), o_hlt(8),
               o_frz(8), o_forced(9), o_def(0), o_def(0)};
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL drain_mem[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        iv.push_back(mi(1,0,0,0,0,0,0,0)); ev.push_back(o_forced(0));
        for (int i = 0; i < 20; i++) begin
            iv.push_back(mi(0,0,1,5,1,5,0,0));
            ev.push_back(o_lu((i > 15) ? 15 : i));
        end
        iv.push_back(mi(0,0,0,0,0,0,0,0)); ev.push_back(o_def(15));
        iv.push_back(mi(1,0,0,0,0,0,0,0)); ev.push_back(o_forced(15));
        iv.push_back(mi(0,0,0,0,0,0,0,0)); ev.push_back(o_def(0));
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL saturate[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_memlat0();
        in_t  iv[$];
        out_t ev[$];
        out_t got, ex;
        drive(mi(1,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        iv = '{mi(0,0,0,0,0,0,1,0), mi(0,0,1,7,7,0,1,0), mi(0,0,0,0,0,0,1,0), mi(0,0,0,0,0,0,0,0)};
        ev = '{o_def(0), o_lu(0), o_def(1), o_def(1)};
        for (int i = 0; i < iv.size(); i++) begin
            drive(iv[i]); sb.push_back(ev[i]);
            @(negedge clk); got = sample0(); ex = sb.pop_front(); checks++;
            if (got !== ex) begin errors++; $display("FAIL memlat0[%0d] got=%b exp=%b", i, got, ex); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drive(mi(1,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_halt();
        test_drain_mem();
        test_saturate();
        test_memlat0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
